// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes and shared-ALU arbiter FSM encoding
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// rtl/alu_share_arbiter_alu.sv - combinational MIPS-style ALU shared by the arbiter
module alu_share_arbiter_alu
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = 8
) (
    input  logic [2:0]           i_op,
    input  logic [ALU_WIDTH-1:0] i_a,
    input  logic [ALU_WIDTH-1:0] i_b,
    output logic [ALU_WIDTH-1:0] o_result,
    output logic                 o_zero,
    output logic                 o_ov
);

    localparam int MSB = ALU_WIDTH - 1;

    logic [ALU_WIDTH-1:0] w_sum;
    logic [ALU_WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    // Opcode decode; unused opcodes yield zero, overflow only meaningful for ADD/SUB
    always_comb begin
        o_result = '0;
        o_ov     = 1'b0;
        case (i_op)
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_ADD: begin
                o_result = w_sum;
                o_ov     = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_result = w_diff;
                o_ov     = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_SLT: o_result = {{(ALU_WIDTH-1){1'b0}}, (i_a < i_b)};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_op,
    input  logic [ALU_WIDTH-1:0] req0_a,
    input  logic [ALU_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_op,
    input  logic [ALU_WIDTH-1:0] req1_a,
    input  logic [ALU_WIDTH-1:0] req1_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_id,
    output logic [ALU_WIDTH-1:0] resp_result,
    output logic                 resp_z,
    output logic                 resp_ov
);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_last_grant;
    logic [2:0]           r_op;
    logic [ALU_WIDTH-1:0] r_a;
    logic [ALU_WIDTH-1:0] r_b;
    logic                 r_id;
    logic                 r_resp_valid;
    logic                 r_resp_id;
    logic [ALU_WIDTH-1:0] r_resp_result;
    logic                 r_resp_z;
    logic                 r_resp_ov;

    logic                 w_grant_id;
    logic                 w_accept;
    logic [ALU_WIDTH-1:0] w_alu_result;
    logic                 w_alu_zero;
    logic                 w_alu_ov;

    // ALU only ever sees the latched operands, never the live request buses
    alu_share_arbiter_alu #(
        .ALU_WIDTH (ALU_WIDTH)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_ov     (w_alu_ov)
    );

    // Round-robin grant, re-evaluated every IDLE cycle; a lone valid always wins
    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    assign w_accept   = (r_state == ST_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    // FSM next state: one operation in flight, response must drain before next accept
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_next_state = ST_EXEC;
            ST_EXEC:                 w_next_state = ST_RESP;
            ST_RESP: if (resp_ready) w_next_state = ST_IDLE;
            default:                 w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture on handshake; last_grant resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_op         <= w_grant_id ? req1_op : req0_op;
            r_a          <= w_grant_id ? req1_a  : req0_a;
            r_b          <= w_grant_id ? req1_b  : req0_b;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

    // Response registers: load in EXEC, hold through backpressure, release on resp_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_resp_z      <= 1'b0;
            r_resp_ov     <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_resp_valid  <= 1'b1;
            r_resp_id     <= r_id;
            r_resp_result <= w_alu_result;
            r_resp_z      <= w_alu_zero;
            r_resp_ov     <= w_alu_ov && ((r_op == OP_ADD) || (r_op == OP_SUB));
        end else if ((r_state == ST_RESP) && resp_ready) begin
            r_resp_valid  <= 1'b0;
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_z      = r_resp_z;
    assign resp_ov     = r_resp_ov;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [2:0] op0 = '0, op1 = '0;
    logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       rr = 1'b1;
    logic       req0_ready, req1_ready;
    logic       resp_valid, resp_id, resp_z, resp_ov;
    logic [7:0] resp_result;

    int total = 0;
    int bad = 0;
    int model_last = 1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.ALU_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (v0),
        .req0_ready  (req0_ready),
        .req0_op     (op0),
        .req0_a      (a0),
        .req0_b      (b0),
        .req1_valid  (v1),
        .req1_ready  (req1_ready),
        .req1_op     (op1),
        .req1_a      (a1),
        .req1_b      (b1),
        .resp_valid  (resp_valid),
        .resp_ready  (rr),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_z      (resp_z),
        .resp_ov     (resp_ov)
    );

    function automatic void ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] res, output logic z, output logic ov);
        int sa, sb, s, ua, ub, u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        u = 0;
        ov = 1'b0;
        case (op)
            3'd0: u = ua & ub;
            3'd1: u = ua | ub;
            3'd2: begin u = ua + ub; s = sa + sb; ov = (s > 127) || (s < -128); end
            3'd6: begin u = ua - ub; s = sa - sb; ov = (s > 127) || (s < -128); end
            3'd7: u = (ua < ub) ? 1 : 0;
            default: u = 0;
        endcase
        res = 8'(u & 255);
        z = (res == 8'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for an accept, checks the grant against round-robin rules, then the response
    task automatic serve(output int gid);
        int         waited;
        int         g;
        int         ga;
        logic [1:0] exp_rdy;
        logic [2:0] op;
        logic [7:0] a, b, er;
        logic       ez, eov;
        #1;
        waited = 0;
        while (!(req0_ready || req1_ready) && waited < 6) begin
            tick();
            #1;
            waited++;
        end
        total++;
        if (!(req0_ready || req1_ready)) begin
            bad++;
            $display("FAIL accept_timeout: ready=%b%b required one ready within 6 cycles", req1_ready, req0_ready);
            gid = -1;
            return;
        end
        if (v0 && v1) g = 1 - model_last;
        else if (v0)  g = 0;
        else          g = 1;
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        total++;
        if ({req1_ready, req0_ready} !== exp_rdy) begin
            bad++;
            $display("FAIL grant: ready={r1,r0}=%b required %b", {req1_ready, req0_ready}, exp_rdy);
        end
        ga = req1_ready ? 1 : 0;
        op = (g == 1) ? op1 : op0;
        a  = (g == 1) ? a1  : a0;
        b  = (g == 1) ? b1  : b0;
        ref_alu(op, a, b, er, ez, eov);
        model_last = g;
        tick();
        if (ga == 1) v1 = 1'b0; else v0 = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL exec_quiet: resp_valid=%b ready=%b%b required 0 00", resp_valid, req1_ready, req0_ready);
        end
        tick();
        #1;
        total++;
        if ({resp_valid, resp_id, resp_result, resp_z, resp_ov} !== {1'b1, (g == 1), er, ez, eov}) begin
            bad++;
            $display("FAIL resp: op=%0d a=%h b=%h got v=%b id=%b r=%h z=%b ov=%b required v=1 id=%0d r=%h z=%b ov=%b",
                     op, a, b, resp_valid, resp_id, resp_result, resp_z, resp_ov, g, er, ez, eov);
        end
        gid = g;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({resp_valid, resp_id, resp_result, resp_z, resp_ov, req0_ready, req1_ready} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: v=%b id=%b r=%h z=%b ov=%b rdy=%b%b required all 0",
                     resp_valid, resp_id, resp_result, resp_z, resp_ov, req1_ready, req0_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        tick();
        tick();
        total++;
        if ({resp_valid, req0_ready, req1_ready} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: v=%b rdy=%b%b required 0 00", resp_valid, req1_ready, req0_ready);
        end
    endtask

    task automatic test_add();
        int g;
        v0 = 1'b1; op0 = 3'd2; a0 = 8'h7F; b0 = 8'h01;
        serve(g);
        total++;
        if (resp_result !== 8'h80 || resp_ov !== 1'b1 || resp_id !== 1'b0) begin
            bad++;
            $display("FAIL add_7f_01: r=%h ov=%b id=%b required 80 1 0", resp_result, resp_ov, resp_id);
        end
        tick();
    endtask

    task automatic test_tie();
        int g0, g1;
        test_reset();
        v0 = 1'b1; op0 = 3'd0; a0 = 8'hF0; b0 = 8'h3C;
        v1 = 1'b1; op1 = 3'd6; a1 = 8'h80; b1 = 8'h01;
        serve(g0);
        serve(g1);
        total++;
        if (g0 != 0 || g1 != 1 || resp_result !== 8'h7F || resp_ov !== 1'b1) begin
            bad++;
            $display("FAIL tie_order: grants=%0d,%0d r=%h ov=%b required 0,1 7f 1", g0, g1, resp_result, resp_ov);
        end
        tick();
    endtask

    task automatic test_alternate();
        int g;
        v0 = 1'b1; op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
        v1 = 1'b1; op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            serve(g);
            total++;
            if (g != (k % 2)) begin
                bad++;
                $display("FAIL alternate: txn %0d grant=%0d required %0d", k, g, k % 2);
            end
            if (g == 0) begin v0 = 1'b1; op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom); end
            else        begin v1 = 1'b1; op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom); end
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int         g;
        logic [11:0] snap;
        v0 = 1'b1; op0 = 3'd2; a0 = 8'($urandom); b0 = 8'($urandom);
        v1 = 1'b1; op1 = 3'd1; a1 = 8'($urandom); b1 = 8'($urandom);
        rr = 1'b0;
        serve(g);
        snap = {resp_valid, resp_id, resp_result, resp_z, resp_ov};
        for (int k = 0; k < 5; k++) begin
            tick();
            #1;
            total++;
            if ({resp_valid, resp_id, resp_result, resp_z, resp_ov} !== snap || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: cycle %0d resp=%h rdy=%b%b required %h 00",
                         k, {resp_valid, resp_id, resp_result, resp_z, resp_ov}, req1_ready, req0_ready, snap);
            end
        end
        rr = 1'b1;
        tick();
        #1;
        total++;
        if (resp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release: v=%b req1_ready=%b required 0 1", resp_valid, req1_ready);
        end
        serve(g);
        tick();
    endtask

    task automatic test_slt_misc();
        int g;
        v0 = 1'b1; op0 = 3'd7; a0 = 8'hFF; b0 = 8'h01;
        serve(g);
        total++;
        if (resp_result !== 8'h00 || resp_z !== 1'b1) begin
            bad++;
            $display("FAIL slt_unsigned: r=%h z=%b required 00 1", resp_result, resp_z);
        end
        v1 = 1'b1; op1 = 3'd4; a1 = 8'h5A; b1 = 8'hA5;
        serve(g);
        total++;
        if (resp_result !== 8'h00 || resp_z !== 1'b1 || resp_ov !== 1'b0) begin
            bad++;
            $display("FAIL op4_zero: r=%h z=%b ov=%b required 00 1 0", resp_result, resp_z, resp_ov);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int waited;
        int seen;
        int g;
        v0 = 1'b1; op0 = 3'd2; a0 = 8'h11; b0 = 8'h22;
        #1;
        waited = 0;
        while (!req0_ready && waited < 6) begin tick(); #1; waited++; end
        tick();
        v0 = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || resp_result !== 8'h00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_midop_async: v=%b r=%h rdy=%b%b required 0 00 00", resp_valid, resp_result, req1_ready, req0_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (resp_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_midop_noresp: resp_valid seen %0d cycles required 0", seen);
        end
        v0 = 1'b1; op0 = 3'd1; a0 = 8'h0F; b0 = 8'hF0;
        v1 = 1'b1; op1 = 3'd0; a1 = 8'hFF; b1 = 8'h00;
        serve(g);
        total++;
        if (g != 0) begin
            bad++;
            $display("FAIL tie_after_reset: grant=%0d required 0", g);
        end
        serve(g);
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 20; k++) begin
            if (!v0 && !v1) begin
                case ($urandom_range(0, 2))
                    0: v0 = 1'b1;
                    1: v1 = 1'b1;
                    default: begin v0 = 1'b1; v1 = 1'b1; end
                endcase
                if (v0) begin op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom); end
                if (v1) begin op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom); end
            end
            serve(g);
            if ($urandom_range(0, 1) == 1) begin
                if (g == 0) begin v0 = 1'b1; op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom); end
                else        begin v1 = 1'b1; op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom); end
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_tie();
        test_alternate();
        test_backpressure();
        test_slt_misc();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
